// File: rtl/win_sum16_if.sv
// Sample-stream bus between the upstream generator and the windowed-sum block.
// The master drives samples and clear; the slave returns the window results.
interface win_sum16_if #(
    parameter int DW    = 9,
    parameter int LOG2N = 4
);
    localparam int SW = DW + LOG2N;

    logic [DW-1:0] din;
    logic          din_vld;
    logic          clr;
    logic [SW-1:0] sum_out;
    logic [DW-1:0] avg_out;
    logic          dout_vld;
    logic          full;

    modport master (
        output din, din_vld, clr,
        input  sum_out, avg_out, dout_vld, full
    );

    modport slave (
        input  din, din_vld, clr,
        output sum_out, avg_out, dout_vld, full
    );
endinterface

// File: rtl/win_sum16.sv
// Running sum and truncated mean over the last 2^LOG2N accepted samples,
// kept with a circular buffer and an add-newest/subtract-oldest accumulator.
module win_sum16 #(
    parameter int DW    = 9,
    parameter int LOG2N = 4
) (
    input logic       clk,
    input logic       res,
    win_sum16_if.slave bus
);
    localparam int N  = 1 << LOG2N;
    localparam int SW = DW + LOG2N;
    localparam logic [LOG2N:0] FILL_LAST = (LOG2N+1)'(N - 1);
    localparam logic [LOG2N:0] FILL_MAX  = (LOG2N+1)'(N);

    typedef enum logic {FILL, RUN} state_t;

    state_t           state, state_nxt;
    logic [LOG2N-1:0] wp, wp_nxt;
    logic [LOG2N:0]   fill, fill_nxt;
    logic [SW-1:0]    acc, acc_nxt;
    logic             dout_vld, dout_vld_nxt;
    logic             we;
    logic [DW-1:0]    oldest;
    logic [SW:0]      din_ext, old_ext, acc_ext;

    logic [DW-1:0] sample_mem [N];

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= FILL;
            wp       <= '0;
            fill     <= '0;
            acc      <= '0;
            dout_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            wp       <= wp_nxt;
            fill     <= fill_nxt;
            acc      <= acc_nxt;
            dout_vld <= dout_vld_nxt;
        end
    end

    // Storage is never reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (we && !res) begin
            sample_mem[wp] <= bus.din;
        end
    end

    always_comb begin
        state_nxt    = state;
        wp_nxt       = wp;
        fill_nxt     = fill;
        acc_nxt      = acc;
        dout_vld_nxt = 1'b0;
        we           = 1'b0;
        oldest       = sample_mem[wp];
        din_ext      = {{(SW+1-DW){1'b0}}, bus.din};
        old_ext      = {{(SW+1-DW){1'b0}}, oldest};
        acc_ext      = {1'b0, acc};

        if (bus.clr) begin
            state_nxt = FILL;
            wp_nxt    = '0;
            fill_nxt  = '0;
            acc_nxt   = '0;
        end else if (bus.din_vld) begin
            we     = 1'b1;
            wp_nxt = wp + LOG2N'(1);
            case (state)
                FILL: begin
                    acc_nxt  = SW'(acc_ext + din_ext);
                    fill_nxt = fill + (LOG2N+1)'(1);
                    if (fill == FILL_LAST) begin
                        state_nxt    = RUN;
                        fill_nxt     = FILL_MAX;
                        dout_vld_nxt = 1'b1;
                    end
                end
                RUN: begin
                    // The oldest sample sits at wp and is read before this edge overwrites it.
                    acc_nxt      = SW'(acc_ext + din_ext - old_ext);
                    dout_vld_nxt = 1'b1;
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    assign bus.sum_out  = acc;
    assign bus.avg_out  = acc[SW-1:LOG2N];
    assign bus.dout_vld = dout_vld;
    assign bus.full     = (state == RUN);
endmodule

// File: tb/tb_win_sum16.sv
// Scoreboard bench for win_sum16: a queue-based window model predicts every cycle,
// plus fixed known-answer checks at the points of interest.
module tb_win_sum16;
    localparam int DW    = 9;
    localparam int LOG2N = 4;
    localparam int N     = 16;

    typedef struct {
        int sum;
        int avg;
        bit vld;
        bit full;
    } exp_t;

    logic clk = 1'b0;
    logic res;

    win_sum16_if #(.DW(DW), .LOG2N(LOG2N)) bus ();

    win_sum16 #(.DW(DW), .LOG2N(LOG2N)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   win[$];
    exp_t sb[$];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: keep the literal window and re-add it each cycle.
    task automatic modelStep(input bit r, input bit c, input bit v, input int d, output exp_t e);
        int s;
        s = 0;
        if (r || c) begin
            win.delete();
        end else if (v) begin
            win.push_back(d);
            if (win.size() > N) void'(win.pop_front());
        end
        foreach (win[i]) s += win[i];
        e.sum  = s;
        e.avg  = s / N;
        e.full = (win.size() == N);
        e.vld  = !r && !c && v && (win.size() == N);
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit v, input int d);
        exp_t e;
        exp_t got;
        res         = r;
        bus.clr     = c;
        bus.din_vld = v;
        bus.din     = DW'(d);
        modelStep(r, c, v, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 0, 1);
        end else begin
            got = sb.pop_front();
            checkOutput("sb_sum",  int'(bus.sum_out),  got.sum);
            checkOutput("sb_avg",  int'(bus.avg_out),  got.avg);
            checkOutput("sb_vld",  int'(bus.dout_vld), int'(got.vld));
            checkOutput("sb_full", int'(bus.full),     int'(got.full));
        end
        res         = 1'b0;
        bus.clr     = 1'b0;
        bus.din_vld = 1'b0;
    endtask

    initial begin
        res         = 1'b1;
        bus.clr     = 1'b0;
        bus.din_vld = 1'b0;
        bus.din     = '0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 1, 77);
        checkOutput("rst_sum",  int'(bus.sum_out),  0);
        checkOutput("rst_avg",  int'(bus.avg_out),  0);
        checkOutput("rst_vld",  int'(bus.dout_vld), 0);
        checkOutput("rst_full", int'(bus.full),     0);

        $display("[TB] sixteen ones");
        for (int i = 0; i < N; i++) begin
            applyStimulus(0, 0, 1, 1);
            if (i < N - 1) checkOutput("ones_no_vld", int'(bus.dout_vld), 0);
        end
        checkOutput("ones_sum",  int'(bus.sum_out),  16);
        checkOutput("ones_avg",  int'(bus.avg_out),  1);
        checkOutput("ones_full", int'(bus.full),     1);
        checkOutput("ones_vld",  int'(bus.dout_vld), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ones_vld_drop", int'(bus.dout_vld), 0);

        $display("[TB] ramp every cycle");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(0, 0, 1, i);
            if (i == 15) begin
                checkOutput("ramp15_sum", int'(bus.sum_out), 120);
                checkOutput("ramp15_avg", int'(bus.avg_out), 7);
            end
            if (i == 16) begin
                checkOutput("ramp16_sum", int'(bus.sum_out), 136);
                checkOutput("ramp16_avg", int'(bus.avg_out), 8);
            end
            if (i >= 15) checkOutput("ramp_vld", int'(bus.dout_vld), 1);
        end

        $display("[TB] max then zero");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < N; i++) applyStimulus(0, 0, 1, 511);
        checkOutput("max_sum", int'(bus.sum_out), 8176);
        checkOutput("max_avg", int'(bus.avg_out), 511);
        for (int i = 0; i < N; i++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("drain_sum", int'(bus.sum_out), 8176 - 511 * (i + 1));
        end
        checkOutput("drain_avg", int'(bus.avg_out), 0);

        $display("[TB] ramp with gaps");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 1, i);
            applyStimulus(0, 0, 0, 0);
            checkOutput("gap_idle_vld", int'(bus.dout_vld), 0);
        end
        checkOutput("gap_sum", int'(bus.sum_out), 184);

        $display("[TB] clear with sample");
        applyStimulus(0, 1, 1, 100);
        checkOutput("clr_sum",  int'(bus.sum_out),  0);
        checkOutput("clr_full", int'(bus.full),     0);
        checkOutput("clr_vld",  int'(bus.dout_vld), 0);
        for (int i = 0; i < N; i++) applyStimulus(0, 0, 1, 5);
        checkOutput("refill_sum", int'(bus.sum_out),  80);
        checkOutput("refill_vld", int'(bus.dout_vld), 1);

        $display("[TB] reset mid-run then triangle");
        applyStimulus(1, 0, 1, 9);
        checkOutput("midrst_sum",  int'(bus.sum_out), 0);
        checkOutput("midrst_full", int'(bus.full),    0);
        for (int i = 0; i < N; i++) begin
            applyStimulus(0, 0, 1, 299 - i);
            if (i < N - 1) checkOutput("tri_no_vld", int'(bus.dout_vld), 0);
        end
        checkOutput("tri_sum", int'(bus.sum_out),  4664);
        checkOutput("tri_avg", int'(bus.avg_out),  291);
        checkOutput("tri_vld", int'(bus.dout_vld), 1);

        // Random tail exercises clr/vld mixes against the model only.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 511)));
        end

        checkOutput("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/win_sum16.md
Name: win_sum16

Overview:
- Downstream consumer of the 9-bit triangle/ramp sample stream.
- Computes the running sum of the most recent 2^LOG2N accepted samples (default 16) and the truncated mean of that window.
- Uses a circular sample buffer plus an add-new/subtract-oldest accumulator. Results feed the next stage, which displays or compares them.

Parameters:
DW, 9, sample width in bits (unsigned)
LOG2N, 4, log2 of window length; N = 2^LOG2N = 16
SW, DW+LOG2N (13), sum width; derived, not overridden

Ports:
clk  input  1  system clock, all logic on rising edge
res  input  1  synchronous reset, active-high
din  input  DW  unsigned sample from upstream generator
din_vld  input  1  din accepted on any rising edge where din_vld=1
clr  input  1  synchronous window clear, active-high
sum_out  output  SW  sum of last N accepted samples
avg_out  output  DW  sum_out >> LOG2N (truncating)
dout_vld  output  1  one-cycle pulse: sum_out/avg_out updated with a full window
full  output  1  window holds N samples since last reset/clear

Behaviour:
- Reset (res=1 at clk edge):
  - sum_out=0, avg_out=0, dout_vld=0, full=0.
  - Write pointer=0, fill count=0, state=FILL.
  - Buffer contents need not be cleared; they are never read until overwritten.
- Priority: res > clr > din_vld. clr acts exactly like reset for all state and outputs. A sample presented with clr=1 is discarded.
- Storage: N-entry x DW buffer, write pointer wp (LOG2N bits) wraps N-1 -> 0. Fill counter counts 0..N, then saturates.
- State FILL (full=0), on accepted sample:
  - buf[wp]<=din, wp<=wp+1, acc<=acc+din, fill<=fill+1.
  - dout_vld stays 0.
  - The N-th accepted sample moves the block to RUN: full<=1, and dout_vld<=1 in the same edge.
- State RUN (full=1), on accepted sample:
  - acc<=acc+din-buf[wp]. buf[wp] is the oldest sample, read before overwrite.
  - buf[wp]<=din, wp<=wp+1, dout_vld<=1.
- No accepted sample in a cycle: acc, wp, state unchanged; dout_vld<=0.
- Latency: one clock. Sample accepted at edge k gives its updated sum_out/avg_out/dout_vld visible after edge k.
- sum_out mirrors acc. It is also visible during FILL as a partial sum, but dout_vld is 0 there.
- avg_out = acc[SW-1:LOG2N], registered together with sum_out.
- Arithmetic: unsigned. Max sum N*(2^DW-1)=8176 fits in SW bits, so overflow is impossible. The intermediate acc+din-old is computed at SW+1 bits; the result is never negative.
- Back-to-back din_vld every cycle is supported with no stalls. There is no backpressure output.
- Reset or clr mid-window: the partial window is discarded, and the next N samples refill the window before dout_vld is asserted again.

Test Plan:
- Reset, then 16 consecutive samples of value 1 -> dout_vld first pulses after the 16th; sum_out=16, avg_out=1, full=1. No dout_vld during samples 1-15.
- Ramp 0,1,2,... every cycle -> after sample 15: sum_out=120, avg_out=7. Each subsequent sample: sum_out +16, avg_out +1 (sample 16 -> 136/8). dout_vld continuously 1.
- 16 samples of 511 -> sum_out=8176, avg_out=511; then 16 samples of 0 -> sum_out decreases by 511 per sample down to 0, with no wrap.
- din_vld toggled 1,0,1,0 with ramp data -> sum_out holds on idle cycles, dout_vld pulses only on the cycle after each accepted sample, and values match the gap-free case.
- Full window, then clr=1 together with din_vld=1, din=100 -> sum_out=0, full=0, dout_vld=0, and sample 100 is not counted. The next 16 samples refill and re-trigger dout_vld on the 16th.
- res=1 mid-RUN for one cycle -> all outputs 0 next cycle. Triangle stream 299 down to 284 afterwards -> first dout_vld with sum_out=4664, avg_out=291.
